rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum grant cycles while another requester waits; legal range 2..255.
REQ-002 The block SHALL have input clk_i, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have input rst_i, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have input req_i, 4 bits: bit k is the request from requester k, held high for the whole use of the shared 32-bit path.
REQ-005 The block SHALL have output grant_o, 4 bits: one-hot owner of the shared path, or all zero.
REQ-006 The block SHALL have output select_o, 2 bits: binary index of the owner, driving the 4:1 32-bit mux select.
REQ-007 The block SHALL have output valid_o, 1 bit: high exactly when grant_o is nonzero, so the mux output is owned.
REQ-008 The block SHALL have output preempt_o, 1 bit: a one-cycle pulse in the cycle a grant is revoked by the hold limit.

Function
REQ-009 All outputs SHALL be registered, with no combinational path from req_i to any output.
REQ-010 The FSM SHALL have three states: IDLE, GRANT and SWITCH.
REQ-011 In IDLE with req_i nonzero at edge n, the FSM SHALL enter GRANT, with grant_o, select_o and valid_o updated after edge n (latency 1 cycle).
REQ-012 Arbitration SHALL be round-robin from pointer ptr (2 bits): the first set req_i bit scanning ptr, ptr+1, ... mod 4 wins.
REQ-013 In GRANT, hold_cnt (8 bits) SHALL be 0 in the first grant cycle, increment each cycle and saturate at MAX_HOLD-1.
REQ-014 GRANT SHALL go to SWITCH when req_i[owner]=0, or when hold_cnt==MAX_HOLD-1 and any other req_i bit is 1 (preemption).
REQ-015 If both REQ-014 conditions hold in the same cycle, release SHALL take priority and preempt_o SHALL stay 0.
REQ-016 With no other requester pending, the owner SHALL keep the grant indefinitely, with hold_cnt saturated.
REQ-017 On entry to SWITCH, ptr SHALL be set to owner+1 mod 4.
REQ-018 In SWITCH, grant_o SHALL be 0 and valid_o 0 for exactly one cycle (handover bubble).
REQ-019 select_o SHALL keep the previous owner index in SWITCH and IDLE.
REQ-020 SWITCH SHALL arbitrate per REQ-012 and go to GRANT if req_i is nonzero, else to IDLE.
REQ-021 A preempted owner still requesting SHALL be lowest priority and SHALL be re-granted if it is the only requester.
REQ-022 preempt_o SHALL be 1 only in the first SWITCH cycle caused by hold-limit preemption.
REQ-023 Requests asserted or dropped during SWITCH SHALL be sampled at the SWITCH exit edge only.
REQ-024 grant_o SHALL never have more than one bit set.
REQ-025 valid_o SHALL equal |grant_o at all times.

Reset
REQ-026 When rst_i=0, the block SHALL asynchronously force state=IDLE, grant_o=0, select_o=0, valid_o=0, preempt_o=0, ptr=0 and hold_cnt=0.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock edge.
REQ-028 After rst_i rises, the first arbitration SHALL occur at the next rising clk_i edge, with ptr=0.

Structure
REQ-029 Shared package rr_arb_pkg SHALL hold the state enum (IDLE/GRANT/SWITCH), the requester count constant 4, the index width 2 and the hold counter width 8.
REQ-030 The rotating priority picker SHALL be a combinational sub-module named rr_pick4, taking a 4-bit request and a 2-bit ptr and returning a 2-bit index plus a found flag.
REQ-031 The FSM, ptr, hold_cnt and output registers SHALL reside in rr_arbiter4.

Verification
REQ-032 Reset then req_i=4'b0100 -> one cycle later grant_o=4'b0100, select_o=2, valid_o=1.
REQ-033 req_i=4'b1111 from IDLE with ptr=0, each owner dropping its request after 2 cycles -> grants in order 0,1,2,3, each separated by a 1-cycle valid_o=0 bubble.
REQ-034 MAX_HOLD=4, req0 held high, req1 rising at grant cycle 1 -> grant0 lasts 4 cycles, then SWITCH with preempt_o=1, then grant_o=4'b0010.
REQ-035 Lone req3 held 300 cycles -> grant_o=4'b1000 throughout, preempt_o never 1.
REQ-036 req2 drops in the same cycle hold_cnt hits MAX_HOLD-1 while req0 pends -> SWITCH with preempt_o=0, then grant_o=4'b0001.
REQ-037 rst_i pulled low mid-grant between clock edges -> all outputs 0 immediately; after release, req_i=4'b1010 grants requester 1 first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the 4-way round-robin arbiter.
//   state_t       - arbiter FSM states (IDLE, GRANT, SWITCH)
//   N_REQ         - number of requesters
//   IDX_W         - width of a requester index
//   HOLD_W        - width of the hold counter
//   idx_to_onehot - convert a requester index to a one-hot grant vector
package rr_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] w_one;
    w_one = {{(N_REQ-1){1'b0}}, 1'b1};
    return w_one << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational rotating-priority picker.
//   i_req   - request vector, bit k = requester k
//   i_ptr   - index holding highest priority this cycle
//   o_idx   - winning index: first set bit scanning ptr, ptr+1, ... mod 4
//   o_found - high when any request is set (o_idx is meaningful)
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Requests rotated so that position 0 is the current priority holder.
  logic [N_REQ-1:0] w_rot;
  logic [IDX_W-1:0] w_off;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    // The 2-bit add wraps naturally, giving the mod-4 rotation.
    assign w_rot[gi] = i_req[i_ptr + IDX_W'(gi)];
  end

  // Scan from the lowest priority upwards so the last hit is the winner.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = IDX_W'(k);
      end
    end
  end

  assign o_idx   = i_ptr + w_off;
  assign o_found = |i_req;

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter for a shared 32-bit path, with a
// hold limit that preempts an owner while another requester waits.
//   MAX_HOLD  - maximum grant cycles while someone else waits (2..255)
//   clk_i     - clock, rising edge
//   rst_i     - asynchronous active-low reset
//   req_i     - request per requester, held for the whole use of the path
//   grant_o   - one-hot owner, or zero
//   select_o  - binary owner index for the 4:1 mux; kept in SWITCH/IDLE
//   valid_o   - high exactly when grant_o is nonzero
//   preempt_o - one-cycle pulse in the SWITCH cycle caused by the hold limit
// All outputs come straight from registers.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] select_o,
  output logic             valid_o,
  output logic             preempt_o
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [N_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]  r_select;
  logic              r_valid;
  logic              r_preempt;

  logic [IDX_W-1:0]  w_idx;
  logic              w_found;
  logic              w_release;
  logic              w_others;
  logic              w_preempt;

  rr_pick4 u_pick (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_idx   (w_idx),
    .o_found (w_found)
  );

  // r_select is the current owner while in GRANT.
  assign w_release = ~req_i[r_select];
  assign w_others  = |(req_i & ~idx_to_onehot(r_select));
  assign w_preempt = (r_hold == HOLD_LAST) && w_others;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_select  <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE, SWITCH: begin
          if (w_found) begin
            r_state  <= GRANT;
            r_grant  <= idx_to_onehot(w_idx);
            r_select <= w_idx;
            r_valid  <= 1'b1;
            r_hold   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        GRANT: begin
          if (w_release || w_preempt) begin
            // Owner moves to lowest priority for the next arbitration.
            r_state   <= SWITCH;
            r_grant   <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= r_select + IDX_W'(1);
            // A voluntary release wins over a simultaneous hold-limit hit.
            r_preempt <= ~w_release;
          end else if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o   = r_grant;
  assign select_o  = r_select;
  assign valid_o   = r_valid;
  assign preempt_o = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: scoreboard bench for rr_arbiter4 (MAX_HOLD = 4).
// Each stimulus step drives req_i at a falling edge and queues the outputs
// expected after the next rising edge; a monitor pops and compares them
// shortly after that rising edge.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       preempt;
  logic [7:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  logic [7:0] exp_q[$];
  string      name_q[$];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .req_i     (req),
    .grant_o   (grant),
    .select_o  (select),
    .valid_o   (valid),
    .preempt_o (preempt)
  );

  assign outs = {grant, select, valid, preempt};

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b (grant,select,valid,preempt)", name, got, exp);
    end else begin
      $display("[%0t] %s ok %b", $time, name, got);
    end
  endtask

  // Monitor: invariants every cycle, plus scoreboard pop when an entry waits.
  always @(posedge clk) begin
    #2;
    if (armed && rst_n) begin
      check("valid_eq_or", {7'd0, valid}, {7'd0, |grant});
      check("onehot0", {7'd0, $onehot0(grant)}, 8'd1);
    end
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), outs, exp_q.pop_front());
    end
  end

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string name, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic v, input logic p);
    req = r;
    exp_q.push_back({g, s, v, p});
    name_q.push_back(name);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("rst_async", outs, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    @(negedge clk);

    // Single request, latency one cycle.
    do_reset();
    step("lone2_grant", 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("lone2_hold",  4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("lone2_rel",   4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("lone2_idle",  4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

    // All four request, each releases after two cycles: 0,1,2,3 with bubbles.
    do_reset();
    step("rr_g0",   4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_g0b",  4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rr_sw0",  4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rr_g1",   4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_g1b",  4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("rr_sw1",  4'b1100, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("rr_g2",   4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_g2b",  4'b1100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rr_sw2",  4'b1000, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("rr_g3",   4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_g3b",  4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("rr_sw3",  4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    step("rr_idle", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Hold-limit preemption: grant0 lasts 4 cycles, then 1, then back to 0.
    do_reset();
    step("pre_g0",    4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("pre_g0h1",  4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("pre_g0h2",  4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("pre_g0h3",  4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("pre_sw0",   4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("pre_g1",    4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("pre_g1h1",  4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("pre_g1h2",  4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("pre_g1h3",  4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("pre_sw1",   4'b0011, 4'b0000, 2'd1, 1'b0, 1'b1);
    step("pre_back0", 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("pre_rel0",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("pre_idle",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Preempted owner re-granted when it is the only one left at SWITCH exit.
    do_reset();
    step("reg_g0",   4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("reg_h1",   4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("reg_h2",   4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("reg_h3",   4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("reg_sw",   4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1);
    step("reg_g0x",  4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("reg_rel",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("reg_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release coinciding with the hold limit: no preempt pulse.
    do_reset();
    step("rel_g2",   4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rel_h1",   4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rel_h2",   4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rel_h3",   4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step("rel_sw",   4'b0001, 4'b0000, 2'd2, 1'b0, 1'b0);
    step("rel_g0",   4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step("rel_rel",  4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step("rel_idle", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Lone requester 3 held 300 cycles: never preempted.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step("lone3", 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    step("lone3_rel",  4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);
    step("lone3_idle", 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0);

    // Move ptr to 2, grant requester 3, then reset between clock edges.
    do_reset();
    step("ar_g1",   4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("ar_sw",   4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("ar_idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
    step("ar_g3",   4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step("ar_g3h",  4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_midgrant", outs, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar_first", 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step("ar_hold",  4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    req = 4'b0000;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d pending required=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
